// File: rtl/tlb.sv
// Fully associative TLB: registered fetch/data lookups with raw fault flags,
// TLBRD/TLBWR/INVTLB support and a free-running TLBFILL index.
module tlb #(
  parameter int TLBNUM = 16,
  localparam int IDXW = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [9:0]      asid,
  input  logic [1:0]      plv,
  // fetch lookup
  input  logic            s0_req,
  input  logic [18:0]     s0_vppn,
  input  logic            s0_va_bit12,
  output logic [19:0]     s0_ppn,
  output logic            s0_found,
  output logic [IDXW-1:0] s0_index,
  output logic            tlb_TLBR0,
  output logic            tlb_PIF,
  // data lookup
  input  logic            s1_req,
  input  logic            s1_load,
  input  logic            s1_store,
  input  logic [18:0]     s1_vppn,
  input  logic            s1_va_bit12,
  output logic [19:0]     s1_ppn,
  output logic            s1_found,
  output logic [IDXW-1:0] s1_index,
  output logic [5:0]      s1_ps,
  output logic            tlb_TLBR1,
  output logic            tlb_PIL,
  output logic            tlb_PIS,
  output logic            tlb_PME,
  output logic            tlb_PPI1,
  // write port
  input  logic            we,
  input  logic [IDXW-1:0] w_index,
  input  logic            w_e,
  input  logic [18:0]     w_vppn,
  input  logic [5:0]      w_ps,
  input  logic [9:0]      w_asid,
  input  logic            w_g,
  input  logic [19:0]     w_ppn0,
  input  logic [1:0]      w_plv0,
  input  logic [1:0]      w_mat0,
  input  logic            w_d0,
  input  logic            w_v0,
  input  logic [19:0]     w_ppn1,
  input  logic [1:0]      w_plv1,
  input  logic [1:0]      w_mat1,
  input  logic            w_d1,
  input  logic            w_v1,
  // read port
  input  logic            r_req,
  input  logic [IDXW-1:0] r_index,
  output logic            r_e,
  output logic [18:0]     r_vppn,
  output logic [5:0]      r_ps,
  output logic [9:0]      r_asid,
  output logic            r_g,
  output logic [19:0]     r_ppn0,
  output logic [1:0]      r_plv0,
  output logic [1:0]      r_mat0,
  output logic            r_d0,
  output logic            r_v0,
  output logic [19:0]     r_ppn1,
  output logic [1:0]      r_plv1,
  output logic [1:0]      r_mat1,
  output logic            r_d1,
  output logic            r_v1,
  // invalidate
  input  logic            inv_req,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [18:0]     inv_vppn,
  output logic [IDXW-1:0] fill_index
);

  localparam logic [5:0] PS_4M = 6'd21;

  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } page_t;

  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    page_t       p0;
    page_t       p1;
  } entry_t;

  entry_t              entries [TLBNUM];
  logic [TLBNUM-1:0]   ent_e;
  logic [TLBNUM-1:0]   e_next;
  logic [TLBNUM-1:0]   m0, m1;
  logic [IDXW-1:0]     idx0, idx1;
  logic                hit0, hit1, odd0, odd1;
  logic [19:0]         ppn_s0, ppn_s1;
  logic                v_s0, v_s1, d_s1;
  logic [1:0]          plv_s1;
  entry_t              w_ent;
  entry_t              r_q;

  function automatic logic va_match(entry_t ent, logic [18:0] vppn);
    if (ent.ps == PS_4M) return ent.vppn[18:9] == vppn[18:9];
    return ent.vppn == vppn;
  endfunction

  function automatic logic inv_match(entry_t ent, logic [4:0] op,
                                     logic [9:0] a, logic [18:0] v);
    logic am, vm;
    am = (ent.asid == a);
    vm = va_match(ent, v);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return ent.g;
      5'd3:       return !ent.g;
      5'd4:       return !ent.g && am;
      5'd5:       return !ent.g && am && vm;
      5'd6:       return (ent.g || am) && vm;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [IDXW-1:0] first_set(logic [TLBNUM-1:0] m);
    first_set = '0;
    for (int i = TLBNUM - 1; i >= 0; i--)
      if (m[i]) first_set = IDXW'(i);
  endfunction

  assign w_ent = '{vppn: w_vppn, ps: w_ps, g: w_g, asid: w_asid,
                   p0: '{ppn: w_ppn0, plv: w_plv0, mat: w_mat0, d: w_d0, v: w_v0},
                   p1: '{ppn: w_ppn1, plv: w_plv1, mat: w_mat1, d: w_d1, v: w_v1}};

  // NOTE: every bit of m0/m1 is assigned on every pass of the loop, so no latch can form.
  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      m0[i] = ent_e[i] && (entries[i].g || entries[i].asid == asid) && va_match(entries[i], s0_vppn);
      m1[i] = ent_e[i] && (entries[i].g || entries[i].asid == asid) && va_match(entries[i], s1_vppn);
    end
  end

  assign hit0   = |m0;
  assign hit1   = |m1;
  assign idx0   = first_set(m0);
  assign idx1   = first_set(m1);
  assign odd0   = (entries[idx0].ps == PS_4M) ? s0_vppn[8] : s0_va_bit12;
  assign odd1   = (entries[idx1].ps == PS_4M) ? s1_vppn[8] : s1_va_bit12;
  assign ppn_s0 = odd0 ? entries[idx0].p1.ppn : entries[idx0].p0.ppn;
  assign v_s0   = odd0 ? entries[idx0].p1.v   : entries[idx0].p0.v;
  assign ppn_s1 = odd1 ? entries[idx1].p1.ppn : entries[idx1].p0.ppn;
  assign v_s1   = odd1 ? entries[idx1].p1.v   : entries[idx1].p0.v;
  assign d_s1   = odd1 ? entries[idx1].p1.d   : entries[idx1].p0.d;
  assign plv_s1 = odd1 ? entries[idx1].p1.plv : entries[idx1].p0.plv;

  // Invalidate sees the entry as it looks after this cycle's write.
  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin : g_next
      logic   written;
      entry_t cur;
      written   = we && (w_index == IDXW'(i));
      cur       = written ? w_ent : entries[i];
      e_next[i] = (written ? w_e : ent_e[i]) &&
                  !(inv_req && inv_match(cur, inv_op, inv_asid, inv_vppn));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ent_e <= '0;
    else       ent_e <= e_next;
  end

  // NOTE: the payload array is not reset; ent_e gates every use of it.
  always_ff @(posedge clk) begin
    if (!reset && we) entries[w_index] <= w_ent;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_found  <= 1'b0;
      s0_index  <= '0;
      s0_ppn    <= '0;
      tlb_TLBR0 <= 1'b0;
      tlb_PIF   <= 1'b0;
    end else if (s0_req) begin
      s0_found  <= hit0;
      s0_index  <= hit0 ? idx0 : '0;
      s0_ppn    <= hit0 ? ppn_s0 : '0;
      tlb_TLBR0 <= !hit0;
      tlb_PIF   <= hit0 && !v_s0;
    end else begin
      tlb_TLBR0 <= 1'b0;
      tlb_PIF   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_found  <= 1'b0;
      s1_index  <= '0;
      s1_ppn    <= '0;
      s1_ps     <= '0;
      tlb_TLBR1 <= 1'b0;
      tlb_PIL   <= 1'b0;
      tlb_PIS   <= 1'b0;
      tlb_PPI1  <= 1'b0;
      tlb_PME   <= 1'b0;
    end else if (s1_req) begin
      s1_found  <= hit1;
      s1_index  <= hit1 ? idx1 : '0;
      s1_ppn    <= hit1 ? ppn_s1 : '0;
      s1_ps     <= hit1 ? entries[idx1].ps : '0;
      tlb_TLBR1 <= !hit1;
      tlb_PIL   <= hit1 && !v_s1 && s1_load;
      tlb_PIS   <= hit1 && !v_s1 && s1_store;
      tlb_PPI1  <= hit1 && v_s1 && (plv > plv_s1);
      tlb_PME   <= hit1 && v_s1 && (plv <= plv_s1) && s1_store && !d_s1;
    end else begin
      tlb_TLBR1 <= 1'b0;
      tlb_PIL   <= 1'b0;
      tlb_PIS   <= 1'b0;
      tlb_PPI1  <= 1'b0;
      tlb_PME   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e <= 1'b0;
      r_q <= '0;
    end else if (r_req) begin
      r_e <= ent_e[r_index];
      r_q <= ent_e[r_index] ? entries[r_index] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) fill_index <= '0;
    else       fill_index <= fill_index + 1'b1;
  end

  assign r_vppn = r_q.vppn;
  assign r_ps   = r_q.ps;
  assign r_asid = r_q.asid;
  assign r_g    = r_q.g;
  assign r_ppn0 = r_q.p0.ppn;
  assign r_plv0 = r_q.p0.plv;
  assign r_mat0 = r_q.p0.mat;
  assign r_d0   = r_q.p0.d;
  assign r_v0   = r_q.p0.v;
  assign r_ppn1 = r_q.p1.ppn;
  assign r_plv1 = r_q.p1.plv;
  assign r_mat1 = r_q.p1.mat;
  assign r_d1   = r_q.p1.d;
  assign r_v1   = r_q.p1.v;

endmodule

// File: tb/tb_tlb.sv
// Scoreboard bench for tlb: stimulus pushes predicted responses from a
// behavioural TLB model; a negedge monitor pops and compares them.
module tb_tlb;
  localparam int N = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [9:0]  asid;
  logic [1:0]  plv;
  logic        s0_req, s0_va_bit12, s0_found, tlb_TLBR0, tlb_PIF;
  logic [18:0] s0_vppn;
  logic [19:0] s0_ppn;
  logic [3:0]  s0_index;
  logic        s1_req, s1_load, s1_store, s1_va_bit12, s1_found;
  logic [18:0] s1_vppn;
  logic [19:0] s1_ppn;
  logic [3:0]  s1_index;
  logic [5:0]  s1_ps;
  logic        tlb_TLBR1, tlb_PIL, tlb_PIS, tlb_PME, tlb_PPI1;
  logic        we;
  logic [3:0]  w_index;
  logic        r_req;
  logic [3:0]  r_index;
  logic        r_e, r_g, r_d0, r_v0, r_d1, r_v1;
  logic [18:0] r_vppn;
  logic [5:0]  r_ps;
  logic [9:0]  r_asid;
  logic [19:0] r_ppn0, r_ppn1;
  logic [1:0]  r_plv0, r_mat0, r_plv1, r_mat1;
  logic        inv_req;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_vppn;
  logic [3:0]  fill_index;

  typedef struct {
    bit e; bit [18:0] vppn; bit [5:0] ps; bit g; bit [9:0] asid;
    bit [19:0] ppn0; bit [1:0] plv0; bit [1:0] mat0; bit d0; bit v0;
    bit [19:0] ppn1; bit [1:0] plv1; bit [1:0] mat1; bit d1; bit v1;
  } ment_t;

  ment_t model [N];
  ment_t wr;

  tlb #(.TLBNUM(N)) dut (
    .clk(clk), .reset(reset), .asid(asid), .plv(plv),
    .s0_req(s0_req), .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12),
    .s0_ppn(s0_ppn), .s0_found(s0_found), .s0_index(s0_index),
    .tlb_TLBR0(tlb_TLBR0), .tlb_PIF(tlb_PIF),
    .s1_req(s1_req), .s1_load(s1_load), .s1_store(s1_store),
    .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12),
    .s1_ppn(s1_ppn), .s1_found(s1_found), .s1_index(s1_index), .s1_ps(s1_ps),
    .tlb_TLBR1(tlb_TLBR1), .tlb_PIL(tlb_PIL), .tlb_PIS(tlb_PIS),
    .tlb_PME(tlb_PME), .tlb_PPI1(tlb_PPI1),
    .we(we), .w_index(w_index), .w_e(wr.e), .w_vppn(wr.vppn), .w_ps(wr.ps),
    .w_asid(wr.asid), .w_g(wr.g),
    .w_ppn0(wr.ppn0), .w_plv0(wr.plv0), .w_mat0(wr.mat0), .w_d0(wr.d0), .w_v0(wr.v0),
    .w_ppn1(wr.ppn1), .w_plv1(wr.plv1), .w_mat1(wr.mat1), .w_d1(wr.d1), .w_v1(wr.v1),
    .r_req(r_req), .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps),
    .r_asid(r_asid), .r_g(r_g),
    .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
    .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1),
    .inv_req(inv_req), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .fill_index(fill_index)
  );

  typedef struct {
    int         due;
    int         kind;   // 0 fetch, 1 data, 2 read, 3 fill
    logic [127:0] val;
    logic [127:0] mask;
  } exp_t;

  exp_t sb [$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   fm = 0;
  logic [127:0] last0_v, last0_m, last1_v, last1_m;

  localparam logic [127:0] FULL0 = (128'd1 << 27) - 1;
  localparam logic [127:0] FULL1 = (128'd1 << 36) - 1;
  localparam logic [127:0] FULLR = (128'd1 << 89) - 1;
  localparam logic [127:0] MISS0 = (128'd1 << 26) | 128'h3;
  localparam logic [127:0] MISS1 = (128'd1 << 35) | 128'h1f;

  function automatic string kname(int k);
    case (k)
      0: return "s0_lookup";
      1: return "s1_lookup";
      2: return "read";
      default: return "fill_index";
    endcase
  endfunction

  function automatic logic [127:0] actual(int k);
    case (k)
      0: return 128'({s0_found, s0_index, s0_ppn, tlb_TLBR0, tlb_PIF});
      1: return 128'({s1_found, s1_index, s1_ppn, s1_ps, tlb_TLBR1, tlb_PIL, tlb_PIS, tlb_PPI1, tlb_PME});
      2: return 128'({r_e, r_vppn, r_ps, r_g, r_asid, r_ppn0, r_plv0, r_mat0, r_d0, r_v0,
                      r_ppn1, r_plv1, r_mat1, r_d1, r_v1});
      default: return 128'(fill_index);
    endcase
  endfunction

  task automatic check(exp_t x, logic [127:0] got);
    n_checks++;
    if (((got ^ x.val) & x.mask) === 128'd0) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h mask=%h",
                  kname(x.kind), cyc, got & x.mask, x.val, x.mask);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        x = sb.pop_front();
        if (x.due < cyc) begin
          n_checks++;
          $display("FAIL %s stale cyc=%0d due=%0d", kname(x.kind), cyc, x.due);
        end else begin
          check(x, actual(x.kind));
        end
      end
    end
  end

  task automatic push(int k, logic [127:0] v, logic [127:0] m);
    exp_t x;
    x.due = cyc + 1; x.kind = k; x.val = v; x.mask = m;
    sb.push_back(x);
  endtask

  // ---------------- reference model ----------------
  function automatic bit va_hit(ment_t t, bit [18:0] v);
    if (t.ps == 6'd21) return t.vppn[18:9] == v[18:9];
    return t.vppn == v;
  endfunction

  function automatic int find(bit [18:0] v, bit [9:0] a);
    for (int i = 0; i < N; i++)
      if (model[i].e && (model[i].g || model[i].asid == a) && va_hit(model[i], v)) return i;
    return -1;
  endfunction

  function automatic bit inv_hit(ment_t t);
    bit am, vm;
    am = (t.asid == inv_asid);
    vm = va_hit(t, inv_vppn);
    case (inv_op)
      5'd0, 5'd1: return 1'b1;
      5'd2: return t.g;
      5'd3: return !t.g;
      5'd4: return !t.g && am;
      5'd5: return !t.g && am && vm;
      5'd6: return (t.g || am) && vm;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [127:0] read_view(ment_t t);
    if (!t.e) return 128'd0;
    return 128'({1'b1, t.vppn, t.ps, t.g, t.asid, t.ppn0, t.plv0, t.mat0, t.d0, t.v0,
                 t.ppn1, t.plv1, t.mat1, t.d1, t.v1});
  endfunction

  // Predict this cycle's responses, advance one clock, then apply state changes.
  task automatic cycle();
    int i;
    bit odd, v, d, pil, pis, ppi, pme;
    bit [19:0] ppn;
    bit [1:0]  pl;
    if (reset) begin
      last0_v = '0; last0_m = FULL0;
      last1_v = '0; last1_m = FULL1;
      push(2, '0, FULLR);
      fm = 0;
    end else begin
      if (s0_req) begin
        i = find(s0_vppn, asid);
        if (i < 0) begin
          last0_v = 128'h2; last0_m = MISS0;
        end else begin
          odd = (model[i].ps == 6'd21) ? s0_vppn[8] : s0_va_bit12;
          ppn = odd ? model[i].ppn1 : model[i].ppn0;
          v   = odd ? model[i].v1 : model[i].v0;
          last0_v = 128'({1'b1, 4'(i), ppn, 1'b0, !v}); last0_m = FULL0;
        end
      end else last0_v = last0_v & ~128'h3;
      if (s1_req) begin
        i = find(s1_vppn, asid);
        if (i < 0) begin
          last1_v = 128'h10; last1_m = MISS1;
        end else begin
          odd = (model[i].ps == 6'd21) ? s1_vppn[8] : s1_va_bit12;
          ppn = odd ? model[i].ppn1 : model[i].ppn0;
          v   = odd ? model[i].v1 : model[i].v0;
          d   = odd ? model[i].d1 : model[i].d0;
          pl  = odd ? model[i].plv1 : model[i].plv0;
          {pil, pis, ppi, pme} = '0;
          if (!v) begin pil = s1_load; pis = s1_store; end
          else if (plv > pl) ppi = 1'b1;
          else if (s1_store && !d) pme = 1'b1;
          last1_v = 128'({1'b1, 4'(i), ppn, model[i].ps, 1'b0, pil, pis, ppi, pme});
          last1_m = FULL1;
        end
      end else last1_v = last1_v & ~128'h1f;
      if (r_req) push(2, read_view(model[r_index]), FULLR);
      fm = (fm + 1) % N;
    end
    push(0, last0_v, last0_m);
    push(1, last1_v, last1_m);
    push(3, 128'(fm), 128'hf);
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < N; k++) model[k].e = 1'b0;
    end else begin
      if (we) model[w_index] = wr;
      if (inv_req)
        for (int k = 0; k < N; k++) if (inv_hit(model[k])) model[k].e = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    s0_req = 0; s1_req = 0; s1_load = 0; s1_store = 0;
    we = 0; r_req = 0; inv_req = 0;
  endtask

  function automatic ment_t mk(bit [18:0] vp, bit [5:0] ps, bit g, bit [9:0] a,
                               bit [19:0] p0, bit v0, bit [19:0] p1, bit v1);
    ment_t t;
    t.e = 1; t.vppn = vp; t.ps = ps; t.g = g; t.asid = a;
    t.ppn0 = p0; t.plv0 = 2'd3; t.mat0 = 2'd1; t.d0 = 1; t.v0 = v0;
    t.ppn1 = p1; t.plv1 = 2'd3; t.mat1 = 2'd1; t.d1 = 1; t.v1 = v1;
    return t;
  endfunction

  task automatic write(int idx, ment_t t);
    wr = t; w_index = 4'(idx); we = 1;
  endtask

  task automatic read(int idx);
    r_req = 1; r_index = 4'(idx); cycle(); r_req = 0;
  endtask

  bit [18:0] pool [8] = '{19'h00010, 19'h00011, 19'h40000, 19'h40100,
                          19'h401FF, 19'h00200, 19'h7FFFF, 19'h00110};

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int t;
    reset = 1; idle();
    wr = mk('0, 6'd12, 0, '0, '0, 0, '0, 0); wr.e = 0;
    w_index = 0; r_index = 0; asid = 0; plv = 0;
    s0_vppn = 0; s0_va_bit12 = 0; s1_vppn = 0; s1_va_bit12 = 0;
    inv_op = 0; inv_asid = 0; inv_vppn = 0;
    repeat (3) cycle();
    reset = 0;

    // empty TLB: fetch miss, then let fill_index wrap
    s0_req = 1; s0_vppn = 19'h1ABCD; cycle(); s0_req = 0;
    repeat (18) cycle();

    // 4KB entry, odd page, asid match / mismatch
    write(3, mk(19'h00010, 6'd12, 0, 10'd5, 20'h12345, 1, 20'h54321, 1)); cycle(); idle();
    asid = 5; s1_req = 1; s1_load = 1; s1_vppn = 19'h00010; s1_va_bit12 = 1; cycle();
    asid = 6; cycle(); idle(); asid = 5;

    // 4MB entry with invalid odd page
    write(4, mk(19'h40000, 6'd21, 1, 10'd0, 20'hAAAAA, 1, 20'hBBBBB, 0)); cycle(); idle();
    s1_req = 1; s1_store = 1; s1_vppn = 19'h40100; cycle();
    s1_store = 0; s1_load = 1; cycle(); idle();

    // privilege and dirty faults
    wr = mk(19'h00200, 6'd12, 1, 10'd0, 20'hCCCCC, 1, 20'hDDDDD, 1);
    wr.plv0 = 0; wr.d0 = 0; w_index = 5; we = 1; cycle(); idle();
    plv = 3; s1_req = 1; s1_store = 1; s1_vppn = 19'h00200; s1_va_bit12 = 0; cycle();
    plv = 0; cycle(); idle();
    s0_req = 1; s0_vppn = 19'h40100; cycle(); idle();

    // INVTLB op 3 and op 7
    write(0, mk(19'h00300, 6'd12, 1, 10'd0, 20'h11111, 1, 20'h22222, 1)); cycle();
    write(1, mk(19'h00301, 6'd12, 0, 10'd5, 20'h33333, 1, 20'h44444, 1)); cycle(); idle();
    inv_req = 1; inv_op = 3; cycle(); idle();
    read(0); read(1); read(3);
    write(1, mk(19'h00301, 6'd12, 0, 10'd5, 20'h33333, 1, 20'h44444, 1)); cycle(); idle();
    inv_req = 1; inv_op = 7; cycle(); idle();
    read(1);

    // write and invalidate together: the freshly written entry is cleared
    write(6, mk(19'h00400, 6'd12, 0, 10'd9, 20'h55555, 1, 20'h66666, 1));
    inv_req = 1; inv_op = 4; inv_asid = 9; cycle(); idle();
    read(6);

    // lookup in the write cycle misses, next cycle hits
    write(2, mk(19'h01234, 6'd12, 1, 10'd0, 20'h77777, 1, 20'h88888, 1));
    s0_req = 1; s0_vppn = 19'h01234; s0_va_bit12 = 0; cycle(); we = 0;
    cycle(); idle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      we = ($urandom_range(0, 9) < 3);
      w_index = 4'($urandom_range(0, N - 1));
      wr.e = ($urandom_range(0, 7) != 0);
      wr.vppn = pool[$urandom_range(0, 7)];
      wr.ps = $urandom_range(0, 1) ? 6'd21 : 6'd12;
      wr.g = 1'($urandom_range(0, 1));
      wr.asid = 10'($urandom_range(0, 3));
      wr.ppn0 = 20'($urandom); wr.ppn1 = 20'($urandom);
      wr.plv0 = 2'($urandom_range(0, 3)); wr.plv1 = 2'($urandom_range(0, 3));
      wr.mat0 = 2'($urandom_range(0, 3)); wr.mat1 = 2'($urandom_range(0, 3));
      {wr.d0, wr.v0, wr.d1, wr.v1} = 4'($urandom);
      asid = 10'($urandom_range(0, 3));
      plv = 2'($urandom_range(0, 3));
      s0_req = 1'($urandom_range(0, 1));
      s0_vppn = pool[$urandom_range(0, 7)];
      s0_va_bit12 = 1'($urandom_range(0, 1));
      s1_req = 1'($urandom_range(0, 1));
      s1_vppn = pool[$urandom_range(0, 7)];
      s1_va_bit12 = 1'($urandom_range(0, 1));
      t = $urandom_range(0, 2);
      s1_load = (t == 0); s1_store = (t == 1);
      r_req = ($urandom_range(0, 3) == 0);
      r_index = 4'($urandom_range(0, N - 1));
      inv_req = ($urandom_range(0, 15) == 0);
      inv_op = 5'($urandom_range(0, 7));
      inv_asid = 10'($urandom_range(0, 3));
      inv_vppn = pool[$urandom_range(0, 7)];
      cycle();
    end

    // reset in the middle of traffic overrides every request
    idle();
    write(7, mk(19'h00010, 6'd12, 1, 10'd0, 20'h99999, 1, 20'h99999, 1));
    s0_req = 1; s1_req = 1; s1_store = 1; r_req = 1; reset = 1; cycle();
    reset = 0; idle();
    read(7);
    s0_req = 1; s0_vppn = 19'h00010; cycle(); idle();
    cycle();

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tlb.md
# tlb

Translation lookaside buffer serving the CPU's address-translation unit: it answers the instruction-fetch lookup (port 0) and load/store lookup (port 1), returning the physical page number and raw page-fault flags (TLBR/PIF/PIL/PIS/PME/PPI) that the translation unit qualifies against direct/DMW mapping. It also executes TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB for the WB-stage CSR logic and supplies the pseudo-random TLBFILL index. Lookups are registered: results appear one cycle after the request.

## Interface
- TLBNUM, 16, entry count (power of two, 4..32); IDXW = log2(TLBNUM)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- asid  in  10  current CSR.ASID.ASID, used by both lookup ports
- plv  in  2  current CSR.CRMD.PLV
- s0_req  in  1  fetch lookup strobe
- s0_vppn  in  19  fetch VA[31:13]; s0_va_bit12 in 1 VA[12]
- s0_ppn  out  20  translated PPN; s0_found out 1; s0_index out IDXW
- tlb_TLBR0, tlb_PIF  out  1 each  fetch fault flags
- s1_req, s1_load, s1_store  in  1 each  data lookup strobe and access type
- s1_vppn  in  19; s1_va_bit12 in 1  data VA fields
- s1_ppn  out  20; s1_found out 1; s1_index out IDXW; s1_ps out 6 (TLBSRCH uses s1)
- tlb_TLBR1, tlb_PIL, tlb_PIS, tlb_PME, tlb_PPI1  out  1 each  data fault flags
- we  in  1; w_index in IDXW; w_e, w_g, w_d0/1, w_v0/1 in 1; w_vppn in 19; w_ps in 6; w_asid in 10; w_ppn0/1 in 20; w_plv0/1, w_mat0/1 in 2 each  write port
- r_req  in  1; r_index in IDXW; r_* out (same fields as w_*)  read port
- inv_req  in  1; inv_op in 5; inv_asid in 10; inv_vppn in 19  INVTLB
- fill_index  out  IDXW  pseudo-random TLBFILL target

## Operation
- Entry = {e, vppn, ps, g, asid, ppn0, plv0, mat0, d0, v0, ppn1, plv1, mat1, d1, v1}; only ps 12 and 21 are legal.
- Match(i, vppn, asid): e & (g | entry.asid==asid) & (ps==21 ? entry.vppn[18:9]==vppn[18:9] : entry.vppn==vppn). Multiple hits: lowest index wins.
- Odd/even select: ps==21 ? vppn[8] : va_bit12; selects page-1 fields when 1.
- Fetch faults (one-hot, priority order): !found -> TLBR0; !v -> PIF. Data faults: !found -> TLBR1; !v -> PIL (load) / PIS (store); plv > entry plv -> PPI1; store & !d -> PME. Flags are only raised if the corresponding req was high.
- Write: on we, entry[w_index] takes all w_* fields at the clock edge.
- Read: on r_req, r_* registers entry[r_index]; invalid entries (e=0) return e=0 and all other fields 0.
- INVTLB ops clear e on matching entries: 0,1 all; 2 g=1; 3 g=0; 4 g=0 & asid==inv_asid; 5 g=0 & asid match & VA match; 6 (g=1 | asid match) & VA match (VA match per ps rule). Ops >6: no change.
- fill_index: free-running counter, +1 every cycle, wraps TLBNUM-1 -> 0.

## Timing
- Reset: all e=0; every output 0 (ppn/index/flags/r_*), fill_index=0.
- Lookup latency 1: req at cycle T -> results valid T+1, held until next req on that port; on a cycle with req low, flags drop to 0 but ppn/index/found hold.
- Write/invalidate at T take effect at edge ending T; a lookup or read issued in T sees old contents, in T+1 new.
- we and inv_req in the same cycle: write applied first, then invalidate evaluated on the written value (written entry can be cleared).
- Both lookup ports, read and write may be active in one cycle with no stall; no busy output.
- reset asserted mid-operation wins over all requests in that cycle.

## Test plan
- Reset, s0_req to any VA -> T+1 s0_found=0, tlb_TLBR0=1, fill_index counts 0,1,2.. wrapping at 15.
- Write idx 3 {vppn=0x00010, ps=12, g=0, asid=5, ppn0=0x12345, v0=1, ppn1=0x54321, v1=1}; asid=5, s1_req load va_bit12=1 -> T+1 s1_found=1, s1_index=3, s1_ppn=0x54321, no flags; asid=6 -> TLBR1.
- 4MB entry ps=21, vppn=0x40000, g=1, v1=0; store with vppn=0x40100 (bit8=1) -> hit, tlb_PIS=1; load -> tlb_PIL=1.
- plv0=0, d0=0, plv=3 store -> PPI1 only; plv=0 store -> PME only.
- Entries g=1 (idx 0) and g=0 asid 5 (idx 1); inv_op=3 -> idx1 e=0, idx0 kept (verify via r_req); inv_op=7 -> no change.
- we to idx 2 and s0_req same VA same cycle -> T+1 miss; repeat next cycle -> hit.
